// File: rtl/spi_wb_pkg.sv
// spi_wb_pkg: shared frame constants and FSM state encoding for the SPI-to-Wishbone master and bridge receiver
package spi_wb_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ = 8'h02;
  localparam int FRAME_BYTES = 4;
  localparam int FRAME_BITS = FRAME_BYTES * 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_HOLD,
    ST_GAP
  } spi_state_e;
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter whose terminal count marks the last cycle of a phase
// Ports: clk, rst_n (async active-low), load_i loads val_i, tc_o high while the count is zero.
module spi_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/spi_wb_frame_master.sv
// spi_wb_frame_master: SPI mode-0 master sending the 4-byte CMD/ADDR_HI/ADDR_LO/DATA frame
// Ports: clk, rst_n (async active-low); req_valid/req_ready with req_cmd, req_addr, req_data;
// busy, done pulse, rd_data readback; spi_sclk, spi_mosi, spi_miso, spi_cs_n.
// Optional feature macro: SPI_FRAME_READBACK_EN captures the MISO byte shifted during DATA into rd_data.
module spi_wb_frame_master
  import spi_wb_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);
  localparam int M1 = CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP;
  localparam int M2 = CS_HOLD > CS_IDLE ? CS_HOLD : CS_IDLE;
  localparam int MAXP = M1 > M2 ? M1 : M2;
  localparam int CW = $clog2(MAXP + 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_LD = CW'(CS_IDLE - 1);

  if (CLK_DIV < 2 || CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_bad_param
    $error("spi_wb_frame_master: CLK_DIV must be >= 2 and CS_SETUP/CS_HOLD/CS_IDLE >= 1");
  end

  spi_state_e    state_q, state_d;
  logic [31:0]   sr_q, sr_d;
  logic [4:0]    bit_q, bit_d;
  logic          done_q, done_d;
  logic          ld, tc, shift, accept, last;
  logic [CW-1:0] ld_val;

  // Each phase loads N-1 on entry and leaves on terminal count, so it lasts exactly N cycles.
  spi_phase_timer #(.W(CW)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(ld),
    .val_i(ld_val),
    .tc_o(tc)
  );

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign last = (bit_q == 5'(FRAME_BITS - 1));

  always_comb begin
    state_d = state_q;
    ld = 1'b0;
    ld_val = '0;
    shift = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = ST_SETUP;
        ld = 1'b1;
        ld_val = SETUP_LD;
      end
      ST_SETUP: if (tc) begin
        state_d = ST_SHIFT_LO;
        ld = 1'b1;
        ld_val = DIV_LD;
      end
      ST_SHIFT_LO: if (tc) begin
        state_d = ST_SHIFT_HI;
        ld = 1'b1;
        ld_val = DIV_LD;
      end
      ST_SHIFT_HI: if (tc) begin
        shift = 1'b1;
        state_d = last ? ST_HOLD : ST_SHIFT_LO;
        ld = 1'b1;
        ld_val = last ? HOLD_LD : DIV_LD;
      end
      ST_HOLD: if (tc) begin
        state_d = ST_GAP;
        ld = 1'b1;
        ld_val = IDLE_LD;
      end
      ST_GAP: if (tc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sr_d = accept ? {req_cmd, req_addr, req_data} : (shift ? {sr_q[30:0], 1'b0} : sr_q);
    bit_d = accept ? '0 : (shift ? bit_q + 1'b1 : bit_q);
    done_d = (state_q == ST_HOLD) && tc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q <= '0;
      bit_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_q <= bit_d;
      done_q <= done_d;
    end
  end

`ifdef SPI_FRAME_READBACK_EN
  logic [7:0] rx_q, rx_d, rd_q, rd_d;
  // MISO is taken on the edge that raises sclk; after 32 bits rx_q holds the DATA-byte samples.
  always_comb begin
    rx_d = ((state_q == ST_SHIFT_LO) && tc) ? {rx_q[6:0], spi_miso} : rx_q;
    rd_d = done_d ? rx_q : rd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= '0;
      rd_q <= '0;
    end else begin
      rx_q <= rx_d;
      rd_q <= rd_d;
    end
  end
  assign rd_data = rd_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rd_data = '0;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign busy = !req_ready;
  assign spi_cs_n = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign spi_sclk = (state_q == ST_SHIFT_HI);
  assign spi_mosi = !spi_cs_n && sr_q[31];
  assign done = done_q;
endmodule
